// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
// Propagate convention throughout: p = a|b (OR-propagate), g = a&b.
package cla_pkg;

    localparam int unsigned CLA_WIDTH_DEFAULT = 32;
    localparam int unsigned CLA_GROUP_DEFAULT = 4;
    localparam int unsigned CLA_GROUP_MAX     = 16;
    localparam int unsigned CLA_NG_DEFAULT    = CLA_WIDTH_DEFAULT / CLA_GROUP_DEFAULT;

    typedef struct packed {
        logic gp;
        logic gg;
    } cla_grp_pg_t;

    // Stage-1 bundle at the default geometry.
    typedef struct packed {
        logic [CLA_WIDTH_DEFAULT-1:0] hs;
        logic [CLA_WIDTH_DEFAULT-1:0] p;
        logic [CLA_WIDTH_DEFAULT-1:0] g;
        logic [CLA_NG_DEFAULT-1:0]    gp;
        logic [CLA_NG_DEFAULT-1:0]    gg;
        logic                         cin;
    } cla_s1_t;

    function automatic logic cla_propagate(input logic x, input logic y);
        return x | y;
    endfunction

    // Group terms over the low n bits; bits at or above n are ignored.
    function automatic cla_grp_pg_t cla_group_pg(input logic [CLA_GROUP_MAX-1:0] p,
                                                 input logic [CLA_GROUP_MAX-1:0] g,
                                                 input int unsigned n);
        cla_grp_pg_t r;
        r.gp = 1'b1;
        r.gg = 1'b0;
        for (int unsigned i = 0; i < CLA_GROUP_MAX; i++) begin
            if (i < n) begin
                r.gg = g[i] | (p[i] & r.gg);
                r.gp = r.gp & p[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_group_lookahead.sv
// One lookahead group: group propagate/generate plus the carry into each bit,
// seeded by c_in.
module cla_group_lookahead
    import cla_pkg::*;
#(
    parameter int unsigned GROUP = CLA_GROUP_DEFAULT
) (
    input  logic [GROUP-1:0] p,
    input  logic [GROUP-1:0] g,
    input  logic             c_in,
    output logic             gp,
    output logic             gg,
    output logic [GROUP-1:0] carry
);

    logic [CLA_GROUP_MAX-1:0] p_pad;
    logic [CLA_GROUP_MAX-1:0] g_pad;
    cla_grp_pg_t              pg;

    always_comb begin
        p_pad            = '0;
        g_pad            = '0;
        p_pad[GROUP-1:0] = p;
        g_pad[GROUP-1:0] = g;
        pg               = cla_group_pg(p_pad, g_pad, GROUP);
        gp               = pg.gp;
        gg               = pg.gg;
    end

    always_comb begin
        carry    = '0;
        carry[0] = c_in;
        for (int unsigned i = 1; i < GROUP; i++) begin
            carry[i] = g[i-1] | (p[i-1] & carry[i-1]);
        end
    end

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder with valid/ready on both sides.
// Optional subtract mode (sub port, a-b) enabled by defining CLA_SUB_EN.
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = CLA_WIDTH_DEFAULT,
    parameter int unsigned GROUP = CLA_GROUP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NG = WIDTH / GROUP;

    typedef struct packed {
        logic [WIDTH-1:0] hs;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [NG-1:0]    gp;
        logic [NG-1:0]    gg;
        logic             cin;
    } s1_t;

    logic             s1_valid, s2_valid;
    logic             adv1, adv2, accept;
    s1_t              s1;
    logic [WIDTH-1:0] b_eff, hs_d, p_d, g_d;
    logic             cin_eff;
    logic [NG-1:0]    gp_d, gg_d;
    logic [WIDTH-1:0] s1_carry_unused;
    logic [NG:0]      grp_c;
    logic [WIDTH-1:0] c_all;
    logic [NG-1:0]    s2_gp_unused, s2_gg_unused;

    assign adv2     = !s2_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;
    assign accept   = in_valid && adv1;
    assign out_valid = s2_valid;

    always_comb begin
        b_eff   = b;
        cin_eff = cin;
`ifdef CLA_SUB_EN
        if (sub) begin
            b_eff   = ~b;
            cin_eff = 1'b1;
        end
`endif
        hs_d = a ^ b_eff;
        g_d  = a & b_eff;
        p_d  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            p_d[i] = cla_propagate(a[i], b_eff[i]);
        end
    end

    // Stage-1 instances only contribute GP/GG; stage-2 instances only carries.
    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group_lookahead #(.GROUP(GROUP)) u_s1_grp (
            .p     (p_d[k*GROUP +: GROUP]),
            .g     (g_d[k*GROUP +: GROUP]),
            .c_in  (1'b0),
            .gp    (gp_d[k]),
            .gg    (gg_d[k]),
            .carry (s1_carry_unused[k*GROUP +: GROUP])
        );

        cla_group_lookahead #(.GROUP(GROUP)) u_s2_grp (
            .p     (s1.p[k*GROUP +: GROUP]),
            .g     (s1.g[k*GROUP +: GROUP]),
            .c_in  (grp_c[k]),
            .gp    (s2_gp_unused[k]),
            .gg    (s2_gg_unused[k]),
            .carry (c_all[k*GROUP +: GROUP])
        );
    end

    always_comb begin
        grp_c    = '0;
        grp_c[0] = s1.cin;
        for (int unsigned k = 0; k < NG; k++) begin
            grp_c[k+1] = s1.gg[k] | (s1.gp[k] & grp_c[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (adv1) begin
            s1_valid <= accept;
            if (accept) begin
                s1 <= '{hs: hs_d, p: p_d, g: g_d, gp: gp_d, gg: gg_d, cin: cin_eff};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= s1.hs ^ c_all;
                cout <= grp_c[NG];
                ovf  <= c_all[WIDTH-1] ^ grp_c[NG];
            end
        end
    end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe; define CLA_SUB_EN to cover subtract mode.
module tb_cla_adder_pipe;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub_i = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int unsigned  n_cmp = 0;
    int unsigned  n_err = 0;
    logic [W+1:0] exp_q[$];
    logic [W+1:0] got_q[$];
    bit           acc, xfr;

    always #5 clk = ~clk;

    cla_adder_pipe #(.WIDTH(W), .GROUP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SUB_EN
        .sub       (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // {sum, cout, ovf} for a+b+cin, or a-b when s is set.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic s);
        logic [W-1:0] yy;
        logic         cc;
        logic [W:0]   full;
        yy   = s ? ~y : y;
        cc   = s ? 1'b1 : ci;
        full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
        return {full[W-1:0], full[W], (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1])};
    endfunction

    // Inputs are stable from #1 after posedge, so the negedge sample sees what the next edge will.
    task automatic cycle();
        @(negedge clk);
        acc = in_valid && in_ready;
        xfr = out_valid && out_ready;
        if (acc) exp_q.push_back(model(a, b, cin, sub_i));
        if (xfr) got_q.push_back({sum, cout, ovf});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int unsigned n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (got_q.size() < exp_q.size() && n < 50) begin
            cycle();
            n++;
        end
    endtask

    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = ci;
        sub_i    = s;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, sum, cout, ovf, in_ready} !== {1'b0, {W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got ov=%b sum=%h cout=%b ovf=%b ir=%b, want 0/0/0/0/1",
                     out_valid, sum, cout, ovf, in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [W+1:0] g;
        out_ready = 1'b1;
        drive(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
        cycle();
        n_cmp++;
        if (acc !== 1'b1) begin n_err++; $display("FAIL basic_accept: got %b want 1", acc); end
        in_valid = 1'b0;
        cycle();
        n_cmp++;
        if (xfr !== 1'b0) begin n_err++; $display("FAIL basic_early: out_valid got %b want 0 one edge after accept", xfr); end
        cycle();
        n_cmp++;
        if (xfr !== 1'b1) begin n_err++; $display("FAIL basic_latency: out_valid got %b want 1 two edges after accept", xfr); end
        drain();
        n_cmp++;
        if (got_q.size() != 1) begin
            n_err++;
            $display("FAIL basic_count: got %0d results want 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            n_cmp++;
            if (g !== {32'h0000_0008, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL basic_sum: got sum=%h cout=%b ovf=%b want 00000008/0/0", g[W+1:2], g[1], g[0]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_arith();
        logic [W-1:0] ta[4]  = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [W-1:0] tb_[4] = '{32'h0000_0003, 32'h0000_0000, 32'h0000_0001, 32'h8000_0000};
        logic         tc[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [W+1:0] te[4]  = '{{32'h0000_0008, 2'b00}, {32'h0000_0000, 2'b10},
                                 {32'h8000_0000, 2'b01}, {32'h0000_0000, 2'b11}};
        int unsigned  idx = 0;
        int unsigned  budget = 0;
        logic [W+1:0] g, e;
        while (idx < 20 && budget < 200) begin
            if (idx < 4) drive(ta[idx], tb_[idx], tc[idx], 1'b0);
            else         drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (acc) idx++;
            budget++;
        end
        drain();
        n_cmp++;
        if (got_q.size() != 20 || exp_q.size() != 20) begin
            n_err++;
            $display("FAIL arith_count: got %0d results (%0d accepted) want 20", got_q.size(), exp_q.size());
        end
        for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            if (i < 4) e = te[i];
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL arith_%0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         i, g[W+1:2], g[1], g[0], e[W+1:2], e[1], e[0]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] oa[4] = '{32'h1111_1111, 32'hF000_0001, 32'h0000_FFFF, 32'h8888_8888};
        logic [W-1:0] ob[4] = '{32'h2222_2222, 32'h1000_0000, 32'h0000_0001, 32'h8888_8888};
        int unsigned  idx = 0;
        int unsigned  rel = 0;
        logic [W+1:0] g, e;
        out_ready = 1'b1;
        drive(oa[0], ob[0], 1'b0, 1'b0);
        cycle();
        if (acc) idx++;
        out_ready = 1'b0;
        drive(oa[1], ob[1], 1'b1, 1'b0);
        cycle();
        if (acc) idx++;
        n_cmp++;
        if (idx != 2) begin n_err++; $display("FAIL bp_two_accepts: got %0d accepts want 2", idx); end
        drive(oa[2], ob[2], 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) begin
            cycle();
            n_cmp++;
            if (acc || !out_valid || in_ready !== 1'b0 || exp_q.size() == 0 ||
                {sum, cout, ovf} !== exp_q[0]) begin
                n_err++;
                $display("FAIL bp_stall_%0d: got acc=%b ov=%b ir=%b sum=%h want acc=0 ov=1 ir=0 sum=%h",
                         s, acc, out_valid, in_ready, sum, (exp_q.size() > 0) ? exp_q[0][W+1:2] : '0);
            end
        end
        out_ready = 1'b1;
        while (got_q.size() < 4 && rel < 20) begin
            if (idx < 4) drive(oa[idx], ob[idx], 1'b0, 1'b0);
            else         in_valid = 1'b0;
            cycle();
            if (acc) idx++;
            rel++;
        end
        n_cmp++;
        if (rel != 4 || idx != 4) begin
            n_err++;
            $display("FAIL bp_release: got %0d cycles for 4 results (%0d accepted) want 4/4", rel, idx);
        end
        drain();
        n_cmp++;
        if (got_q.size() != 4 || exp_q.size() != 4) begin
            n_err++;
            $display("FAIL bp_count: got %0d results for %0d accepts want 4", got_q.size(), exp_q.size());
        end
        for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL bp_order_%0d: got %h want %h", i, g, e);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_midflight();
        logic [W+1:0] g;
        out_ready = 1'b0;
        drive(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0);
        cycle();
        drive(32'h0000_0300, 32'h0000_0400, 1'b0, 1'b0);
        cycle();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || sum !== '0) begin
            n_err++;
            $display("FAIL rst_async: got ov=%b sum=%h want 0/0 right after rst_n falls", out_valid, sum);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (5) cycle();
        n_cmp++;
        if (got_q.size() != 0) begin
            n_err++;
            $display("FAIL rst_discard: got %0d stale results want 0", got_q.size());
        end
        got_q.delete();
        drive(32'd1, 32'd2, 1'b0, 1'b0);
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        n_cmp++;
        if (got_q.size() != 1) begin
            n_err++;
            $display("FAIL rst_next_count: got %0d results want 1 two edges after accept", got_q.size());
        end else begin
            g = got_q.pop_front();
            n_cmp++;
            if (g !== {32'd3, 2'b00}) begin
                n_err++;
                $display("FAIL rst_next_sum: got sum=%h cout=%b ovf=%b want 00000003/0/0", g[W+1:2], g[1], g[0]);
            end
        end
        drain();
        exp_q.delete();
        got_q.delete();
    endtask

`ifdef CLA_SUB_EN
    task automatic test_sub();
        logic [W+1:0] te[3] = '{{32'hFFFF_FFFE, 2'b00}, {32'h7FFF_FFFF, 2'b11}, {32'h0000_0000, 2'b10}};
        logic [W+1:0] g;
        out_ready = 1'b1;
        drive(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1);
        cycle();
        drive(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        cycle();
        drive(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1);
        cycle();
        sub_i = 1'b0;
        drain();
        n_cmp++;
        if (got_q.size() != 3) begin n_err++; $display("FAIL sub_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3 && got_q.size() > 0; i++) begin
            g = got_q.pop_front();
            n_cmp++;
            if (g !== te[i]) begin
                n_err++;
                $display("FAIL sub_%0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         i, g[W+1:2], g[1], g[0], te[i][W+1:2], te[i][1], te[i][0]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_arith();
        test_back_to_back();
        test_reset_midflight();
`ifdef CLA_SUB_EN
        test_sub();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
- Two-stage pipelined carry-lookahead adder built around the team's bitwise propagate/generate cells.
- Conventions for those cells: P = A|B (OR-propagate), G = A&B.
- Stage 1 forms bitwise and group P/G terms and registers them. Stage 2 resolves group carries by lookahead and produces the sum.
- Sits between the operand register file and the ALU result mux, with valid/ready flow control on both sides.

Parameters:
WIDTH, 32, operand/sum width in bits; must be a multiple of GROUP
GROUP, 4, bits per lookahead group; group count NG = WIDTH/GROUP

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b, cin present
in_ready  output  1  stage 1 can accept this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry in
out_valid  output  1  sum/cout valid
out_ready  input  1  consumer accepts this cycle
sum  output  WIDTH  a+b+cin modulo 2^WIDTH
cout  output  1  carry out of MSB
ovf  output  1  signed overflow: carry into MSB XOR cout

Behaviour:
- Reset and clocking: one clock domain. Reset is asynchronous and active-low (rst_n). While rst_n=0, out_valid=0, sum=0, cout=0, ovf=0, s1_valid=0, s2_valid=0, and all data registers are 0.
- Handshake:
  - Accept when in_valid & in_ready.
  - Transfer when out_valid & out_ready.
  - in_valid may drop without a transfer. Operands are sampled only on the accept edge.
- Flow control (per stage, no bubbles under full throughput):
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | (adv2 & s1_valid), which reduces to !s1_valid | adv2.
  - in_ready = adv1, combinational from s1_valid, s2_valid and out_ready only; no path from in_valid.
- Stage 1 (on accept): register the following.
  - hs = a^b.
  - Per-bit p = a|b and g = a&b.
  - Per-group GP[k] = AND of p in group k; GG[k] = g[top] | p[top]&g[top-1] | ... across the group.
  - cin.
  - s1_valid <= 1. If adv1 and no accept, s1_valid <= 0.
- Stage 2 (when adv2):
  - Group carries: C[0] = cin, C[k+1] = GG[k] | GP[k]&C[k].
  - Intra-group carry: c[i+1] = g[i] | p[i]&c[i], seeded by C[k].
  - sum = hs ^ c[WIDTH-1:0]; cout = C[NG]; ovf = c[WIDTH-1]^C[NG].
  - s2_valid <= s1_valid.
- Stability: outputs are registered and hold stable while out_valid & !out_ready.
- Latency: accept at edge N gives out_valid at edge N+2. Throughput is 1 per cycle with out_ready held high.
- Backpressure: out_ready=0 with both stages full gives in_ready=0. The next cycle with out_ready=1 drains stage 2, moves stage 1 to stage 2, and accepts a new operand in the same cycle.
- Wrap-around: sum is modulo 2^WIDTH; the carry appears only on cout.
- Reset mid-operation: in-flight operations are discarded with no output. The first accept after rst_n rises behaves as from an empty pipeline.

Optional Feature:
- Macro: CLA_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands.
  - When sub=1, stage 1 uses ~b in place of b and forces effective cin=1, so sum = a-b. The cin port is ignored for that operation.
  - ovf reflects signed subtraction overflow.
  - cout=1 means no borrow.
- Undefined: no sub port; add only.

Decomposition:
- Package cla_pkg:
  - CLA_WIDTH_DEFAULT=32 and CLA_GROUP_DEFAULT=4.
  - Function computing group GG/GP from GROUP p/g bits.
  - Typedef for a stage-1 bundle {hs, p, g, GP, GG, cin}.
- One sub-module: cla_group_lookahead. Parameterized by GROUP; inputs p, g, c_in; outputs group gp, gg and intra-group carries.
  - Instantiated NG times in stage 1 for GP/GG (c_in unused).
  - Instantiated NG times in stage 2 for the intra-group carries.
- The per-bit propagate uses the existing propagate cell.

Test Plan:
- Basic add: reset, then a=0x0000_0005, b=0x0000_0003, cin=0, out_ready=1 -> two edges after accept, out_valid=1, sum=0x0000_0008, cout=0, ovf=0.
- Full ripple: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1, ovf=0. Exercises every group carry.
- Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001, cin=0 -> sum=0x8000_0000, cout=0, ovf=1. Separately, a=0x8000_0000, b=0x8000_0000 -> sum=0, cout=1, ovf=1.
- Backpressure: stream 4 back-to-back adds with out_ready=0 from cycle 2 -> in_ready drops after 2 accepts, sum holds stable. Release out_ready -> 4 results in order, no loss or duplication, then one per cycle.
- Reset mid-flight: accept 2 ops, assert rst_n=0 for 1 cycle -> out_valid=0 immediately (asynchronous) and neither op ever emerges. A next op 1+2 yields 3 after 2 edges.
- With CLA_SUB_EN: sub=1, a=0x0000_0003, b=0x0000_0005 -> sum=0xFFFF_FFFE, cout=0 (borrow), ovf=0. sub=1, a=0x8000_0000, b=0x0000_0001 -> sum=0x7FFF_FFFF, ovf=1.
